// File: rtl/pow2_step_counter.sv
// Up/down counter stepping by a runtime-selected power of two; bits below the step are preserved.
// Optional sticky overflow flag enabled by defining POW2_STEP_COUNTER_STICKY_OVF_EN.
module pow2_step_counter #(
  parameter int               WIDTH       = 16,
  parameter int               MAX_POWER   = 3,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int              POW_W       = (MAX_POWER > 0) ? $clog2(MAX_POWER + 1) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             dir_i,
  input  logic [POW_W-1:0] pow_i,
  input  logic             sat_i,
  output logic [WIDTH-1:0] data_o,
  output logic             wrap_o,
  output logic             at_limit_o
`ifdef POW2_STEP_COUNTER_STICKY_OVF_EN
  ,
  input  logic             ovf_clr_i,
  output logic             ovf_sticky_o
`endif
);

  logic [POW_W-1:0] p;
  logic [WIDTH-1:0] step, hi_mask, upper;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] data_d;
  logic             wrap_d;

  assign p       = (int'(pow_i) > MAX_POWER) ? POW_W'(MAX_POWER) : pow_i;
  assign step    = {{(WIDTH-1){1'b0}}, 1'b1} << p;
  assign hi_mask = ~(step - {{(WIDTH-1){1'b0}}, 1'b1});
  assign upper   = data_o & hi_mask;

  // Adding/subtracting 2^p touches only U; the extra MSB is U's carry/borrow.
  assign sum  = {1'b0, data_o} + {1'b0, step};
  assign diff = {1'b0, data_o} - {1'b0, step};

  assign at_limit_o = dir_i ? (upper == '0) : (upper == hi_mask);

  always_comb begin
    data_d = data_o;
    wrap_d = 1'b0;
    if (load_i) begin
      data_d = load_data_i;
    end else if (en_i) begin
      if (!dir_i) begin
        wrap_d = sum[WIDTH];
        if (!(sum[WIDTH] && sat_i)) data_d = sum[WIDTH-1:0];
      end else begin
        wrap_d = diff[WIDTH];
        if (!(diff[WIDTH] && sat_i)) data_d = diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_o <= RESET_VALUE;
      wrap_o <= 1'b0;
    end else begin
      data_o <= data_d;
      wrap_o <= wrap_d;
    end
  end

`ifdef POW2_STEP_COUNTER_STICKY_OVF_EN
  // Set has priority so a wrap coinciding with a clear is never lost.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        ovf_sticky_o <= 1'b0;
    else if (wrap_d)    ovf_sticky_o <= 1'b1;
    else if (ovf_clr_i) ovf_sticky_o <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_pow2_step_counter.sv
// Scoreboard bench for pow2_step_counter: directed vectors push expectations, a monitor pops and compares.
`timescale 1ns/1ps
module tb_pow2_step_counter;

  typedef struct {
    logic [7:0] d0; logic w0, l0, c0;
    logic [7:0] d1; logic w1, l1, c1;
    logic       s;  logic cs;
  } exp_t;

  logic       clk = 1'b0, rst_ni = 1'b0;
  logic       en = 1'b0, ld = 1'b0, dir = 1'b0, sat = 1'b0, clr = 1'b0;
  logic       en1 = 1'b0, ld1 = 1'b0;
  logic [1:0] pw = '0;
  logic [2:0] pw1 = '0;
  logic [7:0] ldd = '0;
  logic [7:0] d0, d1;
  logic       w0o, l0o, w1o, l1o, st0, st1;

  exp_t sb[$];
  int   ncmp = 0, nerr = 0;

  always #5 clk = ~clk;

  pow2_step_counter #(.WIDTH(8), .MAX_POWER(3), .RESET_VALUE(8'h00)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en), .load_i(ld), .load_data_i(ldd),
    .dir_i(dir), .pow_i(pw), .sat_i(sat), .data_o(d0), .wrap_o(w0o), .at_limit_o(l0o)
`ifdef POW2_STEP_COUNTER_STICKY_OVF_EN
    , .ovf_clr_i(clr), .ovf_sticky_o(st0)
`endif
  );

  // Second instance with a 3-bit pow_i so exponents above MAX_POWER can be driven.
  pow2_step_counter #(.WIDTH(8), .MAX_POWER(4), .RESET_VALUE(8'h00)) dut1 (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en1), .load_i(ld1), .load_data_i(ldd),
    .dir_i(dir), .pow_i(pw1), .sat_i(sat), .data_o(d1), .wrap_o(w1o), .at_limit_o(l1o)
`ifdef POW2_STEP_COUNTER_STICKY_OVF_EN
    , .ovf_clr_i(1'b0), .ovf_sticky_o(st1)
`endif
  );

`ifndef POW2_STEP_COUNTER_STICKY_OVF_EN
  assign st0 = 1'b0;
  assign st1 = 1'b0;
`endif

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  // Monitor: results of each edge are sampled 2ns after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.c0) begin
          chk("data0", d0, e.d0);
          chk("wrap0", {7'b0, w0o}, {7'b0, e.w0});
          chk("limit0", {7'b0, l0o}, {7'b0, e.l0});
        end
        if (e.c1) begin
          chk("data1", d1, e.d1);
          chk("wrap1", {7'b0, w1o}, {7'b0, e.w1});
          chk("limit1", {7'b0, l1o}, {7'b0, e.l1});
        end
`ifdef POW2_STEP_COUNTER_STICKY_OVF_EN
        if (e.cs) chk("sticky", {7'b0, st0}, {7'b0, e.s});
`endif
      end
    end
  end

  // Drive DUT0 for one edge and push its expected result.
  task automatic t0(input logic l, input logic [7:0] dat, input logic e_, input logic dr,
                    input logic [1:0] p, input logic s_, input logic c,
                    input logic [7:0] ed, input logic ew, input logic el,
                    input logic cs, input logic es);
    exp_t x;
    @(negedge clk);
    ld = l; ldd = dat; en = e_; dir = dr; pw = p; sat = s_; clr = c;
    ld1 = 1'b0; en1 = 1'b0;
    x.d0 = ed; x.w0 = ew; x.l0 = el; x.c0 = 1'b1;
    x.d1 = '0; x.w1 = 1'b0; x.l1 = 1'b0; x.c1 = 1'b0;
    x.s = es; x.cs = cs;
    sb.push_back(x);
  endtask

  task automatic t1(input logic l, input logic [7:0] dat, input logic e_, input logic dr,
                    input logic [2:0] p, input logic [7:0] ed, input logic ew, input logic el);
    exp_t x;
    @(negedge clk);
    ld1 = l; ldd = dat; en1 = e_; dir = dr; pw1 = p; sat = 1'b0; clr = 1'b0;
    ld = 1'b0; en = 1'b0;
    x.d0 = '0; x.w0 = 1'b0; x.l0 = 1'b0; x.c0 = 1'b0;
    x.d1 = ed; x.w1 = ew; x.l1 = el; x.c1 = 1'b1;
    x.s = 1'b0; x.cs = 1'b0;
    sb.push_back(x);
  endtask

  initial begin
    #12;
    chk("rst_data", d0, 8'h00);
    chk("rst_wrap", {7'b0, w0o}, 8'h00);
    @(negedge clk); rst_ni = 1'b1;

    // Async reset in the middle of counting
    t0(1, 8'h37, 0, 0, 2'd0, 0, 0, 8'h37, 0, 0, 0, 0);
    @(negedge clk); ld = 1'b0; en = 1'b1;
    #2 rst_ni = 1'b0;
    #1;
    chk("async_rst_data", d0, 8'h00);
    chk("async_rst_wrap", {7'b0, w0o}, 8'h00);
    @(negedge clk); en = 1'b0; rst_ni = 1'b1;

    // Up by 4, wrap, low bits kept
    t0(1, 8'hF5, 0, 0, 2'd2, 0, 0, 8'hF5, 0, 0, 0, 0);
    t0(0, 8'h00, 1, 0, 2'd2, 0, 0, 8'hF9, 0, 0, 0, 0);
    t0(0, 8'h00, 1, 0, 2'd2, 0, 0, 8'hFD, 0, 1, 0, 0);
    t0(0, 8'h00, 1, 0, 2'd2, 0, 0, 8'h01, 1, 0, 0, 0);
    t0(0, 8'h00, 0, 0, 2'd2, 0, 0, 8'h01, 0, 0, 0, 0);

    // Down by 1, saturating at zero
    t0(1, 8'h03, 0, 1, 2'd0, 1, 0, 8'h03, 0, 0, 0, 0);
    t0(0, 8'h00, 1, 1, 2'd0, 1, 0, 8'h02, 0, 0, 0, 0);
    t0(0, 8'h00, 1, 1, 2'd0, 1, 0, 8'h01, 0, 0, 0, 0);
    t0(0, 8'h00, 1, 1, 2'd0, 1, 0, 8'h00, 0, 1, 0, 0);
    t0(0, 8'h00, 1, 1, 2'd0, 1, 0, 8'h00, 1, 1, 0, 0);
    t0(0, 8'h00, 1, 1, 2'd0, 1, 0, 8'h00, 1, 1, 0, 0);
    t0(0, 8'h00, 0, 1, 2'd0, 1, 0, 8'h00, 0, 1, 0, 0);

    // Up saturation holds value, low bit preserved
    t0(1, 8'hFE, 0, 0, 2'd1, 1, 0, 8'hFE, 0, 1, 0, 0);
    t0(0, 8'h00, 1, 0, 2'd1, 1, 0, 8'hFE, 1, 1, 0, 0);

    // Down wrap with non-zero lower field
    t0(1, 8'h05, 0, 1, 2'd2, 0, 0, 8'h05, 0, 0, 0, 0);
    t0(0, 8'h00, 1, 1, 2'd2, 0, 0, 8'h01, 0, 1, 0, 0);
    t0(0, 8'h00, 1, 1, 2'd2, 0, 0, 8'hFD, 1, 0, 0, 0);

    // Largest step on the default instance
    t0(1, 8'hF8, 0, 0, 2'd3, 0, 0, 8'hF8, 0, 1, 0, 0);
    t0(0, 8'h00, 1, 0, 2'd3, 0, 0, 8'h00, 1, 0, 0, 0);

    // Load beats enable
    t0(1, 8'hAA, 1, 0, 2'd0, 0, 0, 8'hAA, 0, 0, 0, 0);

    // Sticky flag: clear, set, set-wins-over-clear, clear
    t0(1, 8'h00, 0, 1, 2'd0, 0, 1, 8'h00, 0, 1, 1, 0);
    t0(0, 8'h00, 1, 1, 2'd0, 0, 0, 8'hFF, 1, 0, 1, 1);
    t0(0, 8'h00, 1, 0, 2'd0, 0, 1, 8'h00, 1, 0, 1, 1);
    t0(0, 8'h00, 0, 0, 2'd0, 0, 1, 8'h00, 0, 0, 1, 0);

    // Exponent clamp on the MAX_POWER=4 instance
    t1(1, 8'hF8, 0, 0, 3'd7, 8'hF8, 0, 1);
    t1(0, 8'h00, 1, 0, 3'd7, 8'h08, 1, 0);
    t1(0, 8'h00, 1, 1, 3'd5, 8'hF8, 1, 0);
    t1(0, 8'h00, 1, 1, 3'd3, 8'hF0, 0, 0);

    @(negedge clk);
    ld = 1'b0; en = 1'b0; ld1 = 1'b0; en1 = 1'b0; clr = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      ncmp++; nerr++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
